cls_spi_sender: RTL and testbench

CLS_SPI_SENDER -- requirements
Module: cls_spi_sender

---
 rtl/cls_spi_sender.sv | 139 +++++++++++++
 tb/tb_cls_spi_sender.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cls_spi_sender.sv
// Sends NUM_BYTES lookup bytes to a PmodCLS over SPI mode 0, one SS frame per byte.
// Define CLS_AUTO_REPEAT_EN to resend the message continuously after each DONE.
module cls_spi_sender #(
  parameter int NUM_BYTES = 6,
  parameter int CLK_DIV   = 50,
  parameter int BYTE_GAP  = 10000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  output logic [5:0] sel,
  input  logic [7:0] data_in,
  output logic       busy,
  output logic       done,
  output logic       SS,
  output logic       SCLK,
  output logic       MOSI
);

  // state | meaning
  // IDLE  | waiting for start, SS high
  // LOAD  | capture data_in for current sel, SS low, MOSI = bit 7
  // SHIFT | eight SCLK periods, MSB first
  // GAP   | SS high for BYTE_GAP cycles, then next byte or DONE
  // DONE  | one-cycle done pulse
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, GAP, DONE} state_t;

  localparam int HALF_W = $clog2(CLK_DIV + 1);
  localparam int GAP_W  = $clog2(BYTE_GAP + 1);
  localparam logic [HALF_W-1:0] HALF_LOAD = HALF_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(BYTE_GAP - 1);
  localparam logic [5:0]        LAST_SEL  = 6'(NUM_BYTES - 1);

  state_t            state, state_n;
  logic [5:0]        sel_n;
  logic [HALF_W-1:0] half_cnt, half_cnt_n;
  logic [2:0]        bit_cnt, bit_cnt_n;
  logic [GAP_W-1:0]  gap_cnt, gap_cnt_n;
  logic [7:0]        shreg, shreg_n;
  logic              sclk_q, sclk_n;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      sel      <= '0;
      half_cnt <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      shreg    <= '0;
      sclk_q   <= 1'b0;
    end else begin
      state    <= state_n;
      sel      <= sel_n;
      half_cnt <= half_cnt_n;
      bit_cnt  <= bit_cnt_n;
      gap_cnt  <= gap_cnt_n;
      shreg    <= shreg_n;
      sclk_q   <= sclk_n;
    end
  end

  always_comb begin
    state_n    = state;
    sel_n      = sel;
    half_cnt_n = half_cnt;
    bit_cnt_n  = bit_cnt;
    gap_cnt_n  = gap_cnt;
    shreg_n    = shreg;
    sclk_n     = sclk_q;

    case (state)
      IDLE: begin
        if (start) begin
          sel_n   = '0;
          state_n = LOAD;
        end
      end
      LOAD: begin
        shreg_n    = data_in;
        half_cnt_n = HALF_LOAD;
        bit_cnt_n  = 3'd7;
        sclk_n     = 1'b0;
        state_n    = SHIFT;
      end
      SHIFT: begin
        if (half_cnt == '0) begin
          half_cnt_n = HALF_LOAD;
          if (!sclk_q) begin
            sclk_n = 1'b1;
          end else begin
            // falling edge: present the next bit
            sclk_n  = 1'b0;
            shreg_n = {shreg[6:0], 1'b0};
            if (bit_cnt == '0) begin
              half_cnt_n = '0;
              gap_cnt_n  = GAP_LOAD;
              state_n    = GAP;
            end else begin
              bit_cnt_n = bit_cnt - 3'd1;
            end
          end
        end else begin
          half_cnt_n = half_cnt - HALF_W'(1);
        end
      end
      GAP: begin
        if (gap_cnt == '0) begin
          if (sel < LAST_SEL) begin
            sel_n   = sel + 6'd1;
            state_n = LOAD;
          end else begin
            state_n = DONE;
          end
        end else begin
          gap_cnt_n = gap_cnt - GAP_W'(1);
        end
      end
      DONE: begin
        sel_n = '0;
`ifdef CLS_AUTO_REPEAT_EN
        state_n = LOAD;
`else
        state_n = IDLE;
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
    SS   = !((state == LOAD) || (state == SHIFT));
    SCLK = sclk_q;
    // during LOAD the register has not captured yet, so bit 7 comes straight from the lookup
    MOSI = (state == LOAD) ? data_in[7] : shreg[7];
  end

endmodule

// File: tb/tb_cls_spi_sender.sv
// Randomized bench for cls_spi_sender: cycle-offset reference model plus literal timing/byte checks.
// Honours CLS_AUTO_REPEAT_EN when the design is built with it.
module tb_cls_spi_sender;
  localparam int NB  = 6;
  localparam int CD  = 2;
  localparam int GP  = 4;
  localparam int PER = 1 + 16*CD + GP;
  localparam int MSG = NB*PER + 1;
`ifdef CLS_AUTO_REPEAT_EN
  localparam bit REPEAT = 1'b1;
`else
  localparam bit REPEAT = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       start = 1'b0;
  logic       corrupt = 1'b0;
  logic [5:0] sel;
  logic [7:0] data_in;
  logic       busy, done, SS, SCLK, MOSI;
  logic [7:0] lut [0:63];
  logic [7:0] ref_bytes [0:5];

  assign data_in = corrupt ? 8'hFF : lut[sel];

  cls_spi_sender #(.NUM_BYTES(NB), .CLK_DIV(CD), .BYTE_GAP(GP)) dut (
    .CLK(CLK), .RST(RST), .start(start), .sel(sel), .data_in(data_in),
    .busy(busy), .done(done), .SS(SS), .SCLK(SCLK), .MOSI(MOSI)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int phase = 0;
  int t_start = 0;
  bit active = 1'b0;
  int t0 = 0;

  int done_n, dec_cnt, bitn, rise_first, last_rise, rint_min, rint_max;
  int gap_min, gap_max, low_run, high_run, ss_low_first, busy_low;
  int done_off [0:1];
  bit low_rec, seen_low, prev_sclk, prev_ss;
  logic [7:0] shb;
  logic [7:0] dec [0:5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // position inside the current message (0 = LOAD of byte 0), or -1 when idle
  function automatic int msg_pos(input int k);
    int m;
    if (!active) return -1;
    m = k - t0;
    if (m < 0) return -1;
    if (REPEAT) m = m % MSG;
    if (m >= MSG) return -1;
    return m;
  endfunction

  function automatic bit is_load(input int k);
    int m;
    m = msg_pos(k);
    return (m >= 0) && (m < NB*PER) && (m % PER == 0);
  endfunction

  task automatic exp_at(input int k, output logic e_ss, output logic e_sclk, output logic e_mosi,
                        output logic e_busy, output logic e_done, output logic [5:0] e_sel);
    int m, b, r, s;
    logic [7:0] bv;
    m = msg_pos(k);
    e_ss = 1'b1; e_sclk = 1'b0; e_mosi = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_sel = '0;
    if (m >= 0) begin
      e_busy = 1'b1;
      if (m == NB*PER) begin
        e_done = 1'b1;
        e_sel  = 6'(NB - 1);
      end else begin
        b = m / PER;
        r = m % PER;
        e_sel = 6'(b);
        bv = lut[b];
        if (r == 0) begin
          e_ss   = 1'b0;
          e_mosi = bv[7];
        end else if (r <= 16*CD) begin
          s      = r - 1;
          e_ss   = 1'b0;
          e_sclk = ((s % (2*CD)) >= CD);
          e_mosi = bv[7 - s/(2*CD)];
        end
      end
    end
  endtask

  task automatic clear_mon();
    done_n = 0; done_off[0] = -1; done_off[1] = -1;
    dec_cnt = 0; bitn = 0; rise_first = 0; last_rise = -1;
    rint_min = 1000; rint_max = -1; gap_min = 1000; gap_max = -1;
    low_run = 0; high_run = 0; ss_low_first = -1; busy_low = 0;
    low_rec = 1'b0; seen_low = 1'b0; prev_sclk = 1'b0; prev_ss = 1'b1; shb = '0;
    for (int i = 0; i < 6; i++) dec[i] = '0;
  endtask

  task automatic mon_p1(input int off);
    if (done) begin
      if (done_n < 2) done_off[done_n] = off;
      done_n++;
    end
    if (off == MSG + 1) chk("busy_after_msg", 32'(busy), REPEAT ? 32'd1 : 32'd0);
    if (!SS && SCLK && !prev_sclk && off < MSG) begin
      if (!low_rec) rise_first++;
      if (last_rise >= 0) begin
        if (cyc - last_rise < rint_min) rint_min = cyc - last_rise;
        if (cyc - last_rise > rint_max) rint_max = cyc - last_rise;
      end
      last_rise = cyc;
      shb = {shb[6:0], MOSI};
      bitn++;
      if (bitn == 8) begin
        if (dec_cnt < 6) dec[dec_cnt] = shb;
        dec_cnt++;
        bitn = 0;
      end
    end
    if (!SS) begin
      if (prev_ss) begin
        if (seen_low && off < MSG) begin
          if (high_run < gap_min) gap_min = high_run;
          if (high_run > gap_max) gap_max = high_run;
        end
        last_rise = -1;
        low_run = 0;
      end
      low_run++;
      seen_low = 1'b1;
    end else begin
      if (!prev_ss) begin
        if (!low_rec) begin
          ss_low_first = low_run;
          low_rec = 1'b1;
        end
        high_run = 0;
      end
      high_run++;
    end
    prev_sclk = SCLK;
    prev_ss = SS;
  endtask

  task automatic eval(input int p);
    case (p)
      1: begin
        chk("decoded_count", 32'(dec_cnt), 32'd6);
        for (int i = 0; i < 6; i++) chk($sformatf("decoded_byte%0d", i), 32'(dec[i]), 32'(ref_bytes[i]));
        chk("done_count_p1", 32'(done_n), REPEAT ? 32'd2 : 32'd1);
        chk("done_offset0", 32'(done_off[0]), 32'd223);
`ifdef CLS_AUTO_REPEAT_EN
        chk("done_offset1", 32'(done_off[1]), 32'd446);
`endif
        chk("ss_low_len", 32'(ss_low_first), 32'd33);
        chk("sclk_rises_byte0", 32'(rise_first), 32'd8);
        chk("rise_interval_min", 32'(rint_min), 32'd4);
        chk("rise_interval_max", 32'(rint_max), 32'd4);
        chk("ss_gap_min", 32'(gap_min), 32'd4);
        chk("ss_gap_max", 32'(gap_max), 32'd4);
      end
      2: begin
        chk("idle_cycles_held_start", 32'(busy_low), REPEAT ? 32'd0 : 32'd1);
        chk("done_count_p2", 32'(done_n), 32'd2);
      end
      3: chk("done_after_abort", 32'(done_n), 32'd0);
      default: ;
    endcase
  endtask

  initial begin : compare
    logic e_ss, e_sclk, e_mosi, e_busy, e_done;
    logic [5:0] e_sel;
    int prev_phase, off;
    prev_phase = 0;
    clear_mon();
    forever begin
      @(negedge CLK);
      if (phase != prev_phase) begin
        eval(prev_phase);
        clear_mon();
        prev_phase = phase;
      end
      if (!RST) begin
        chk("rst_ss", 32'(SS), 32'd1);
        chk("rst_sclk", 32'(SCLK), 32'd0);
        chk("rst_mosi", 32'(MOSI), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        active = 1'b0;
      end else begin
        exp_at(cyc, e_ss, e_sclk, e_mosi, e_busy, e_done, e_sel);
        chk("ss", 32'(SS), 32'(e_ss));
        chk("sclk", 32'(SCLK), 32'(e_sclk));
        chk("sel", 32'(sel), 32'(e_sel));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(e_done));
        if (!e_ss) chk("mosi", 32'(MOSI), 32'(e_mosi));
        off = cyc - t_start;
        if (phase == 1) begin
          mon_p1(off);
        end else if (phase == 2) begin
          if (off >= 1 && off <= 300 && !busy) busy_low++;
          if (done) done_n++;
        end else if (phase == 3) begin
          if (done) done_n++;
        end
        if (!e_busy && start) begin
          active = 1'b1;
          t0 = cyc + 1;
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge CLK);
    #2;
  endtask

  task automatic do_reset();
    RST = 1'b0; start = 1'b0; corrupt = 1'b0;
    repeat (3) next_cycle();
    RST = 1'b1;
    repeat (2) next_cycle();
  endtask

  initial begin : stim
    int rst_hold;
    for (int i = 0; i < 64; i++) lut[i] = 8'($urandom);
    ref_bytes = '{8'h1B, 8'h5B, 8'h6A, 8'h30, 8'h31, 8'h32};
    for (int i = 0; i < 6; i++) lut[i] = ref_bytes[i];
    next_cycle();
    do_reset();

    phase = 1; t_start = cyc; start = 1'b1;
    next_cycle();
    start = 1'b0;
    repeat (REPEAT ? 459 : 239) next_cycle();
    phase = 0;
    do_reset();

    phase = 2; t_start = cyc; start = 1'b1;
    repeat (300) next_cycle();
    start = 1'b0;
    repeat (170) next_cycle();
    phase = 0;
    do_reset();

    // abort during bit 3 of byte 2
    phase = 3; t_start = cyc; start = 1'b1;
    next_cycle();
    start = 1'b0;
    repeat (88) next_cycle();
    RST = 1'b0;
    repeat (3) next_cycle();
    RST = 1'b1;
    repeat (30) next_cycle();

    phase = 4; rst_hold = 0;
    repeat (4000) begin
      next_cycle();
      if (!RST) begin
        for (int i = 0; i < 6; i++) lut[i] = 8'($urandom);
        rst_hold--;
        if (rst_hold <= 0) RST = 1'b1;
      end else if ($urandom_range(0, 599) == 0) begin
        RST = 1'b0; start = 1'b0; corrupt = 1'b0;
        rst_hold = int'($urandom_range(1, 3));
      end else begin
        if (msg_pos(cyc) < 0 && $urandom_range(0, 3) == 0)
          for (int i = 0; i < 6; i++) lut[i] = 8'($urandom);
        start = ($urandom_range(0, 29) == 0);
        corrupt = !is_load(cyc) && ($urandom_range(0, 1) == 1);
      end
    end
    phase = 0; RST = 1'b1; start = 1'b0; corrupt = 1'b0;
    repeat (5) next_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
